// File: rtl/sram16_arbiter.sv
// sram16_arbiter: shares one SRAM controller port between instruction-fetch (m0) and data-cache (m1) masters.
// Optional build macro SRAM16_ARB_FIXED_PRIO_EN makes master 0 win every tie instead of round-robin.
module sram16_arbiter #(
  parameter int BURST_LENGTH = 4,
  parameter int CNTW         = 3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [29:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_writedatamask,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [29:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_writedatamask,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic        stray_return
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  localparam logic [CNTW-1:0] CNT_BURST = CNTW'(BURST_LENGTH);
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [1:0]      ID0       = 2'd1;
  localparam logic [1:0]      ID1       = 2'd2;

  state_t        state_r;
  logic          last_r;      // 1: master 1 was served last, so master 0 wins the next tie
  logic [CNTW-1:0] cnt0_r, cnt1_r;
  logic          stray_r;
  logic [29:0]   addr_hold_r;
  logic [31:0]   wdata_hold_r;
  logic [3:0]    mask_hold_r;

  logic elig0_s, elig1_s, valid0_s, valid1_s, acc0_s, acc1_s, pick0_s;

  // Eligibility, return-word routing and acceptance qualifiers
  always_comb begin
    elig0_s  = m0_write | (m0_read & (cnt0_r == CNT_ZERO));
    elig1_s  = m1_write | (m1_read & (cnt1_r == CNT_ZERO));
    valid0_s = !rst && (mem_readdataid == ID0) && (cnt0_r != CNT_ZERO);
    valid1_s = !rst && (mem_readdataid == ID1) && (cnt1_r != CNT_ZERO);
    acc0_s   = (state_r == G0) & (m0_read | m0_write) & !mem_waitrequest;
    acc1_s   = (state_r == G1) & (m1_read | m1_write) & !mem_waitrequest;
  end

  // Tie-break: decide whether master 0 takes the next grant out of IDLE
  always_comb begin
`ifdef SRAM16_ARB_FIXED_PRIO_EN
    pick0_s = elig0_s;
`else
    pick0_s = elig0_s & (!elig1_s | last_r);
`endif
  end

  // Arbiter state machine and last-served tracking
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick0_s)      state_r <= G0;
          else if (elig1_s) state_r <= G1;
          else              state_r <= IDLE;
        end
        G0: begin
          if (acc0_s) begin
            state_r <= IDLE;
            last_r  <= 1'b0;
          end else if (!(m0_read | m0_write)) begin
            state_r <= IDLE;   // illegal drop: release without crediting the master
          end else begin
            state_r <= G0;
          end
        end
        G1: begin
          if (acc1_s) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
          end else if (!(m1_read | m1_write)) begin
            state_r <= IDLE;
          end else begin
            state_r <= G1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Outstanding-word counters; a read acceptance load wins over a same-cycle decrement
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt0_r <= CNT_ZERO;
      cnt1_r <= CNT_ZERO;
    end else begin
      if (acc0_s && m0_read) cnt0_r <= CNT_BURST;
      else if (valid0_s)     cnt0_r <= cnt0_r - CNT_ONE;
      else                   cnt0_r <= cnt0_r;
      if (acc1_s && m1_read) cnt1_r <= CNT_BURST;
      else if (valid1_s)     cnt1_r <= cnt1_r - CNT_ONE;
      else                   cnt1_r <= cnt1_r;
    end
  end

  // Sticky flag for returned words that match no outstanding read
  always_ff @(posedge clock) begin
    if (rst)                                                   stray_r <= 1'b0;
    else if ((mem_readdataid != 2'd0) && !valid0_s && !valid1_s) stray_r <= 1'b1;
    else                                                       stray_r <= stray_r;
  end

  // Capture the granted master's datapath so it holds once the grant ends
  always_ff @(posedge clock) begin
    if (rst) begin
      addr_hold_r  <= 30'd0;
      wdata_hold_r <= 32'd0;
      mask_hold_r  <= 4'd0;
    end else if (state_r == G0) begin
      addr_hold_r  <= m0_address;
      wdata_hold_r <= m0_writedata;
      mask_hold_r  <= m0_writedatamask;
    end else if (state_r == G1) begin
      addr_hold_r  <= m1_address;
      wdata_hold_r <= m1_writedata;
      mask_hold_r  <= m1_writedatamask;
    end else begin
      addr_hold_r  <= addr_hold_r;
      wdata_hold_r <= wdata_hold_r;
      mask_hold_r  <= mask_hold_r;
    end
  end

  // Request mux toward the controller; control outputs forced idle while in reset
  always_comb begin
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_id            = 2'd0;
    mem_address       = addr_hold_r;
    mem_writedata     = wdata_hold_r;
    mem_writedatamask = mask_hold_r;
    m0_waitrequest    = 1'b1;
    m1_waitrequest    = 1'b1;
    case (state_r)
      G0: begin
        mem_address       = m0_address;
        mem_writedata     = m0_writedata;
        mem_writedatamask = m0_writedatamask;
        if (rst) begin
          mem_id = 2'd0;
        end else begin
          mem_read       = m0_read;
          mem_write      = m0_write;
          mem_id         = ID0;
          m0_waitrequest = mem_waitrequest;
        end
      end
      G1: begin
        mem_address       = m1_address;
        mem_writedata     = m1_writedata;
        mem_writedatamask = m1_writedatamask;
        if (rst) begin
          mem_id = 2'd0;
        end else begin
          mem_read       = m1_read;
          mem_write      = m1_write;
          mem_id         = ID1;
          m1_waitrequest = mem_waitrequest;
        end
      end
      default: mem_id = 2'd0;
    endcase
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = valid0_s;
  assign m1_readdatavalid = valid1_s;
  assign stray_return     = stray_r;

endmodule

// File: tb/tb_sram16_arbiter.sv
// Self-checking bench for sram16_arbiter: directed scenarios, then randomized traffic against
// a transaction-level model (grant owner, outstanding words per master, return queue).
module tb_sram16_arbiter;
  localparam int BL = 4;
`ifdef SRAM16_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst;
  logic [29:0] m0_address, m1_address, mem_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic [3:0]  m0_writedatamask, m1_writedatamask, mem_writedatamask;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic mem_waitrequest, mem_read, mem_write, stray_return;
  logic [1:0] mem_id, mem_readdataid;

  sram16_arbiter #(.BURST_LENGTH(BL), .CNTW(3)) dut (
    .clock(clock), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_writedatamask(m0_writedatamask),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_writedatamask(m1_writedatamask),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid), .stray_return(stray_return)
  );

  always #5 clock = ~clock;

  int checks = 0, passes = 0, fails = 0;

  // Reference model: who owns the port (-1 none), last served master, words still owed per master
  int g_m = -1, last_m = 1;
  int out_m[2];
  bit stray_m = 1'b0;
  bit acc_m[2];
  logic [29:0] hold_a = 30'd0;
  logic [31:0] hold_d = 32'd0;
  logic [3:0]  hold_k = 4'd0;
  int retq[$];
  bit ret_pop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_rd(input int n);  return (n == 0) ? m0_read : m1_read; endfunction
  function automatic logic get_wr(input int n);  return (n == 0) ? m0_write : m1_write; endfunction
  function automatic logic [29:0] get_a(input int n); return (n == 0) ? m0_address : m1_address; endfunction
  function automatic logic [31:0] get_d(input int n); return (n == 0) ? m0_writedata : m1_writedata; endfunction
  function automatic logic [3:0]  get_k(input int n); return (n == 0) ? m0_writedatamask : m1_writedatamask; endfunction

  // Advance one clock; the model evaluates the rules from the pre-edge inputs
  task automatic step();
    int ng, nl, no0, no1, rid;
    bit ns, e0, e1;
    ng = g_m; nl = last_m; no0 = out_m[0]; no1 = out_m[1]; ns = stray_m;
    acc_m[0] = 1'b0; acc_m[1] = 1'b0;
    rid = int'(mem_readdataid);
    if (rst) begin
      ng = -1; nl = 1; no0 = 0; no1 = 0; ns = 1'b0;
      hold_a = 30'd0; hold_d = 32'd0; hold_k = 4'd0;
      retq.delete(); ret_pop = 1'b0;
    end else begin
      if (rid == 1) begin
        if (out_m[0] > 0) no0--; else ns = 1'b1;
      end else if (rid == 2) begin
        if (out_m[1] > 0) no1--; else ns = 1'b1;
      end else if (rid == 3) ns = 1'b1;
      if (g_m >= 0) begin
        hold_a = get_a(g_m); hold_d = get_d(g_m); hold_k = get_k(g_m);
      end
      if (g_m < 0) begin
        e0 = m0_write || (m0_read && out_m[0] == 0);
        e1 = m1_write || (m1_read && out_m[1] == 0);
        if (e0 && e1) ng = (FIXED || last_m == 1) ? 0 : 1;
        else if (e0) ng = 0;
        else if (e1) ng = 1;
      end else if ((get_rd(g_m) || get_wr(g_m)) && !mem_waitrequest) begin
        acc_m[g_m] = 1'b1; nl = g_m; ng = -1;
        if (get_rd(g_m)) begin
          if (g_m == 0) no0 = BL; else no1 = BL;
          for (int k = 0; k < BL; k++) retq.push_back(g_m + 1);
        end
      end else if (!get_rd(g_m) && !get_wr(g_m)) ng = -1;
    end
    @(posedge clock);
    g_m = ng; last_m = nl; out_m[0] = no0; out_m[1] = no1; stray_m = ns;
    if (ret_pop && retq.size() > 0) void'(retq.pop_front());
    ret_pop = 1'b0;
    #1;
  endtask

  // Controller return path: emit the oldest owed word with probability pct
  task automatic ctrl_drive(input int pct);
    if (retq.size() > 0 && $urandom_range(0, 99) < pct) begin
      mem_readdataid = 2'(retq[0]);
      mem_readdata   = $urandom;
      ret_pop        = 1'b1;
    end else begin
      mem_readdataid = 2'd0;
      ret_pop        = 1'b0;
    end
  endtask

  task automatic check_model();
    logic e_rd, e_wr, e_w0, e_w1, e_v0, e_v1;
    logic [1:0] e_id;
    logic [29:0] e_a;
    logic [31:0] e_d;
    logic [3:0] e_k;
    e_rd = 1'b0; e_wr = 1'b0; e_id = 2'd0; e_w0 = 1'b1; e_w1 = 1'b1;
    e_a = hold_a; e_d = hold_d; e_k = hold_k;
    if (g_m >= 0) begin
      e_rd = get_rd(g_m); e_wr = get_wr(g_m); e_id = 2'(g_m + 1);
      e_a = get_a(g_m); e_d = get_d(g_m); e_k = get_k(g_m);
      if (g_m == 0) e_w0 = mem_waitrequest; else e_w1 = mem_waitrequest;
    end
    e_v0 = (mem_readdataid == 2'd1) && (out_m[0] > 0);
    e_v1 = (mem_readdataid == 2'd2) && (out_m[1] > 0);
    chk("rnd_mem_read", mem_read, e_rd);
    chk("rnd_mem_write", mem_write, e_wr);
    chk("rnd_mem_id", mem_id, e_id);
    chk("rnd_addr", mem_address, e_a);
    chk("rnd_wdata", mem_writedata, e_d);
    chk("rnd_mask", mem_writedatamask, e_k);
    chk("rnd_wait0", m0_waitrequest, e_w0);
    chk("rnd_wait1", m1_waitrequest, e_w1);
    chk("rnd_valid0", m0_readdatavalid, e_v0);
    chk("rnd_valid1", m1_readdatavalid, e_v1);
    chk("rnd_rdata1", m1_readdata, mem_readdata);
    chk("rnd_stray", stray_return, stray_m);
  endtask

  task automatic drive_master(input int n);
    logic rd;
    if (acc_m[n]) begin
      if (n == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else        begin m1_read = 1'b0; m1_write = 1'b0; end
    end
    if (!get_rd(n) && !get_wr(n) && $urandom_range(0, 3) == 0) begin
      rd = 1'($urandom_range(0, 1));
      if (n == 0) begin
        m0_read = rd; m0_write = !rd; m0_address = 30'($urandom);
        m0_writedata = $urandom; m0_writedatamask = 4'($urandom);
      end else begin
        m1_read = rd; m1_write = !rd; m1_address = 30'($urandom);
        m1_writedata = $urandom; m1_writedatamask = 4'($urandom);
      end
    end
  endtask

  initial begin
    int n0, n1, ng;
    int ids[4];
    int cyc[4];
    int exp_ids[4];
    out_m[0] = 0; out_m[1] = 0;
    rst = 1'b1;
    m0_address = 30'd0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'd0; m0_writedatamask = 4'd0;
    m1_address = 30'd0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'd0; m1_writedatamask = 4'd0;
    mem_waitrequest = 1'b0; mem_readdata = 32'd0; mem_readdataid = 2'd0;
    repeat (2) step();

    // Reset values
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_id", mem_id, 2'd0);
    chk("rst_wait0", m0_waitrequest, 1'b1);
    chk("rst_wait1", m1_waitrequest, 1'b1);
    chk("rst_valid0", m0_readdatavalid, 1'b0);
    chk("rst_stray", stray_return, 1'b0);
    rst = 1'b0;
    step();

    // Single read: visible one cycle after request, then four tagged returns
    m0_address = 30'h100; m0_read = 1'b1; #1;
    chk("rd_idle_mem_read", mem_read, 1'b0);
    chk("rd_idle_wait0", m0_waitrequest, 1'b1);
    step();
    chk("rd_mem_read", mem_read, 1'b1);
    chk("rd_mem_id", mem_id, 2'd1);
    chk("rd_mem_addr", mem_address, 30'h100);
    chk("rd_wait0", m0_waitrequest, 1'b0);
    step();
    m0_read = 1'b0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      mem_readdataid = (i >= 1 && i <= 4) ? 2'd1 : 2'd0;
      mem_readdata = 32'hA000_0000 + 32'(i); #1;
      n0 += int'(m0_readdatavalid); n1 += int'(m1_readdatavalid);
      if (i == 1) chk("rd_data", m0_readdata, 32'hA000_0001);
      step();
    end
    chk("rd_pulses0", n0, 4);
    chk("rd_pulses1", n1, 0);
    chk("rd_no_stray", stray_return, 1'b0);

    // Counter back at 0: an immediate new read is granted next cycle
    m0_address = 30'h104; m0_read = 1'b1; #1;
    step();
    chk("rd_regrant", mem_read, 1'b1);
    step();
    m0_read = 1'b0;

    // Write while two words are still owed
    for (int i = 0; i < 2; i++) begin
      mem_readdataid = 2'd1; #1;
      chk("wr_pre_valid", m0_readdatavalid, 1'b1);
      step();
    end
    mem_readdataid = 2'd0;
    m0_address = 30'h300; m0_write = 1'b1; m0_writedata = 32'hDEADBEEF; m0_writedatamask = 4'b0011; #1;
    step();
    chk("wr_mem_write", mem_write, 1'b1);
    chk("wr_mem_read", mem_read, 1'b0);
    chk("wr_data", mem_writedata, 32'hDEADBEEF);
    chk("wr_mask", mem_writedatamask, 4'b0011);
    chk("wr_addr", mem_address, 30'h300);
    chk("wr_id", mem_id, 2'd1);
    chk("wr_wait0", m0_waitrequest, 1'b0);
    step();
    m0_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_readdataid = 2'd1; #1;
      chk("wr_post_valid", m0_readdatavalid, 1'b1);
      step();
    end
    mem_readdataid = 2'd0;
    m0_address = 30'h108; m0_read = 1'b1; #1;
    step();
    chk("wr_cnt_regrant", mem_read, 1'b1);
    chk("wr_cnt_addr", mem_address, 30'h108);
    step();
    m0_read = 1'b0;

    // Reset in the middle of that burst
    for (int i = 0; i < 2; i++) begin
      mem_readdataid = 2'd1; #1;
      chk("mid_valid", m0_readdatavalid, 1'b1);
      step();
    end
    mem_readdataid = 2'd0; rst = 1'b1; m0_read = 1'b1; #1;
    step();
    chk("mid_rst_mem_read", mem_read, 1'b0);
    chk("mid_rst_mem_id", mem_id, 2'd0);
    chk("mid_rst_wait0", m0_waitrequest, 1'b1);
    chk("mid_rst_wait1", m1_waitrequest, 1'b1);
    chk("mid_rst_stray", stray_return, 1'b0);
    m0_read = 1'b0; rst = 1'b0; mem_readdataid = 2'd1; #1;
    chk("mid_no_valid", m0_readdatavalid, 1'b0);
    step();
    mem_readdataid = 2'd0; #1;
    chk("mid_stray_set", stray_return, 1'b1);

    // Stray return with id 2 and no outstanding read; flag is sticky
    rst = 1'b1; step(); rst = 1'b0; step();
    chk("stray_cleared", stray_return, 1'b0);
    mem_readdataid = 2'd2; #1;
    chk("stray_no_valid1", m1_readdatavalid, 1'b0);
    step();
    mem_readdataid = 2'd0;
    chk("stray_set", stray_return, 1'b1);
    repeat (3) step();
    chk("stray_sticky", stray_return, 1'b1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Controller stall during a master 1 write
    m1_address = 30'h55; m1_write = 1'b1; m1_writedata = 32'h1234_5678; m1_writedatamask = 4'hF;
    mem_waitrequest = 1'b1; #1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_wait1", m1_waitrequest, 1'b1);
      chk("stall_write", mem_write, 1'b1);
      chk("stall_addr", mem_address, 30'h55);
      chk("stall_data", mem_writedata, 32'h1234_5678);
      step();
    end
    mem_waitrequest = 1'b0; #1;
    chk("stall_release", m1_waitrequest, 1'b0);
    step();
    m1_write = 1'b0; #1;
    chk("stall_done_write", mem_write, 1'b0);
    chk("stall_hold_addr", mem_address, 30'h55);
    step();

    // Write ties: round-robin alternates, fixed priority always master 0
    m0_write = 1'b1; m1_write = 1'b1; m0_address = 30'h10; m1_address = 30'h20;
    ng = 0;
    for (int c = 0; c < 12 && ng < 4; c++) begin
      #1;
      if (mem_write && !mem_waitrequest) begin ids[ng] = int'(mem_id); ng++; end
      step();
    end
    m0_write = 1'b0; m1_write = 1'b0;
    step();
    chk("wtie_count", ng, 4);
    exp_ids = FIXED ? '{1, 1, 1, 1} : '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) chk("wtie_id", ids[i], exp_ids[i]);

    // Read ties: masters wait for their bursts, grants alternate
    retq.delete();
    m0_read = 1'b1; m1_read = 1'b1; m0_address = 30'h40; m1_address = 30'h80;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      ctrl_drive(100); #1;
      if (mem_read && !mem_waitrequest) begin ids[ng] = int'(mem_id); cyc[ng] = c; ng++; end
      step();
    end
    m0_read = 1'b0; m1_read = 1'b0;
    chk("rtie_count", ng, 4);
    exp_ids = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++) chk("rtie_id", ids[i], exp_ids[i]);
    chk("rtie_cyc_m0_second", cyc[2], 7);
    chk("rtie_cyc_m1_second", cyc[3], 11);
    for (int c = 0; c < 20; c++) begin ctrl_drive(100); step(); end
    mem_readdataid = 2'd0;
    chk("rtie_no_stray", stray_return, 1'b0);

    // Randomized traffic against the model
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int c = 0; c < 600; c++) begin
      drive_master(0);
      drive_master(1);
      mem_waitrequest = ($urandom_range(0, 3) == 0);
      ctrl_drive(60);
      #1;
      check_model();
      step();
    end
    chk("rnd_final_stray", stray_return, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
